// File: rtl/f_pc_npc_pkg.sv
// Shared definitions for the F-stage PC / next-PC block: NPCOp encodings and address constants.
package f_pc_npc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'b000,
        NPC_BR  = 3'b001,
        NPC_J   = 3'b010,
        NPC_JR  = 3'b011
    } npc_op_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] PC_LO    = 32'h0000_3000;
    localparam logic [31:0] PC_HI    = 32'h0000_6FFC;

endpackage

// File: rtl/f_pc_npc_if.sv
// D-stage control/operand bundle into the F-stage PC block, plus its F-stage outputs.
interface f_pc_npc_if;
    logic        stall;
    logic [2:0]  NPCOp;
    logic        b_result;
    logic [31:0] D_PC;
    logic [15:0] D_imm16;
    logic [25:0] D_instr_index;
    logic [31:0] D_rs_val;
    logic [31:0] F_PC;
    logic [31:0] D_link;
    logic        F_ExcAdEL;

    modport master (
        output stall, NPCOp, b_result, D_PC, D_imm16, D_instr_index, D_rs_val,
        input  F_PC, D_link, F_ExcAdEL
    );

    modport slave (
        input  stall, NPCOp, b_result, D_PC, D_imm16, D_instr_index, D_rs_val,
        output F_PC, D_link, F_ExcAdEL
    );
endinterface

// File: rtl/f_pc_npc_npc_calc.sv
// Combinational next-PC selection: sequential, taken branch, j/jal and jr targets.
module npc_calc
    import f_pc_npc_pkg::*;
(
    input  logic [2:0]  NPCOp,
    input  logic        b_result,
    input  logic [31:0] F_PC,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_instr_index,
    input  logic [31:0] D_rs_val,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] j_pc;

    always_comb begin
        seq_pc = F_PC + 32'd4;
        // Branch offset is relative to the delay-slot address, D_PC+4.
        br_pc  = D_PC + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
        j_pc   = {D_PC[31:28], D_instr_index, 2'b00};
        npc    = seq_pc;
        case (NPCOp)
            NPC_SEQ: npc = seq_pc;
            NPC_BR:  npc = b_result ? br_pc : seq_pc;
            NPC_J:   npc = j_pc;
            NPC_JR:  npc = D_rs_val;
            default: npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/f_pc_npc.sv
// F-stage PC register with stall/reset priority; optional fetch address-error flag
// built only when NPC_ALIGN_EXC_EN is defined.
module f_pc_npc
    import f_pc_npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC_VAL = RESET_PC
) (
    input logic          clk,
    input logic          reset,
    f_pc_npc_if.slave    bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] npc;

    npc_calc u_npc_calc (
        .NPCOp         (bus.NPCOp),
        .b_result      (bus.b_result),
        .F_PC          (pc_q),
        .D_PC          (bus.D_PC),
        .D_imm16       (bus.D_imm16),
        .D_instr_index (bus.D_instr_index),
        .D_rs_val      (bus.D_rs_val),
        .npc           (npc)
    );

    always_comb begin
        pc_d = bus.stall ? pc_q : npc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.F_PC   = pc_q;
    assign bus.D_link = bus.D_PC + 32'd8;

`ifdef NPC_ALIGN_EXC_EN
    logic exc_q;
    logic exc_d;

    always_comb begin
        exc_d = exc_q;
        if (!bus.stall) begin
            exc_d = (pc_d[1:0] != 2'b00) || (pc_d < PC_LO) || (pc_d > PC_HI);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= exc_d;
        end
    end

    assign bus.F_ExcAdEL = exc_q;
`else
    assign bus.F_ExcAdEL = 1'b0;
`endif

endmodule

// File: tb/tb_f_pc_npc.sv
// Self-checking bench for f_pc_npc: directed scenarios then randomized cycles against a
// behavioural next-PC model.
module tb_f_pc_npc;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    logic [31:0] exp_pc;
    logic        exp_exc;

    f_pc_npc_if bus ();

    f_pc_npc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_npc(input logic [2:0] op, input logic b,
                                              input logic [31:0] fpc, input logic [31:0] dpc,
                                              input logic [15:0] imm, input logic [25:0] idx,
                                              input logic [31:0] rs);
        int          off;
        logic [31:0] offu;
        logic [31:0] idxw;
        off  = $signed(imm);
        offu = off * 4;
        idxw = {6'd0, idx};
        if (op == 3'd1 && b) return dpc + 32'd4 + offu;
        if (op == 3'd2)      return (dpc & 32'hF000_0000) | (idxw * 4);
        if (op == 3'd3)      return rs;
        return fpc + 32'd4;
    endfunction

    function automatic logic model_exc(input logic [31:0] pc);
`ifdef NPC_ALIGN_EXC_EN
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
`else
        return pc === 32'hxxxx_xxxx;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, update the model from the inputs seen at that edge, then check.
    task automatic tick(input string tag);
        logic [31:0] nxt;
        nxt = model_npc(bus.NPCOp, bus.b_result, exp_pc, bus.D_PC, bus.D_imm16,
                        bus.D_instr_index, bus.D_rs_val);
        @(posedge clk);
        #1;
        if (reset) begin
            exp_pc  = 32'h3000;
            exp_exc = 1'b0;
        end else if (!bus.stall) begin
            exp_pc  = nxt;
            exp_exc = model_exc(nxt);
        end
        chk({tag, ".F_PC"}, bus.F_PC, exp_pc);
        chk({tag, ".F_ExcAdEL"}, {31'd0, bus.F_ExcAdEL}, {31'd0, exp_exc});
        chk({tag, ".D_link"}, bus.D_link, bus.D_PC + 32'd8);
    endtask

    task automatic drive(input logic [2:0] op, input logic b, input logic [31:0] dpc,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs,
                         input logic st);
        bus.NPCOp         = op;
        bus.b_result      = b;
        bus.D_PC          = dpc;
        bus.D_imm16       = imm;
        bus.D_instr_index = idx;
        bus.D_rs_val      = rs;
        bus.stall         = st;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_pc   = 32'h0;
        exp_exc  = 1'b0;
        reset    = 1'b1;
        drive(3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
        tick("reset");
        chk("reset_pc_const", bus.F_PC, 32'h0000_3000);
        reset = 1'b0;

        drive(3'd0, 1'b0, 32'h2FFC, 16'h0, 26'h0, 32'h0, 1'b0);
        tick("seq1");
        chk("seq1_const", bus.F_PC, 32'h3004);
        drive(3'd0, 1'b0, 32'h3000, 16'h0, 26'h0, 32'h0, 1'b0);
        tick("seq2");
        drive(3'd0, 1'b0, 32'h3004, 16'h0, 26'h0, 32'h0, 1'b0);
        tick("seq3");
        chk("seq3_const", bus.F_PC, 32'h300C);
        chk("dlink_const", bus.D_link, 32'h300C);

        drive(3'd1, 1'b1, 32'h3004, 16'hFFFF, 26'h0, 32'h0, 1'b0);
        tick("br_taken");
        chk("br_taken_const", bus.F_PC, 32'h3004);
        drive(3'd1, 1'b0, 32'h3004, 16'hFFFF, 26'h0, 32'h0, 1'b0);
        tick("br_not_taken");
        chk("br_nt_const", bus.F_PC, 32'h3008);

        drive(3'd2, 1'b0, 32'h3010, 16'h0, 26'h0000C10, 32'h0, 1'b0);
        tick("j");
        chk("j_const", bus.F_PC, 32'h0000_3040);
        drive(3'd3, 1'b0, 32'h3040, 16'h0, 26'h0, 32'h3100, 1'b0);
        tick("jr");
        chk("jr_const", bus.F_PC, 32'h3100);

        drive(3'd3, 1'b0, 32'h3104, 16'h0, 26'h0, 32'h0, 1'b1);
        tick("jr_stall1");
        drive(3'd3, 1'b0, 32'h3104, 16'h0, 26'h0, 32'h3200, 1'b1);
        tick("jr_stall2");
        chk("jr_stall_hold", bus.F_PC, 32'h3100);
        bus.stall = 1'b0;
        tick("jr_release");
        chk("jr_release_const", bus.F_PC, 32'h3200);

        drive(3'd1, 1'b1, 32'h3200, 16'h0010, 26'h0, 32'h0, 1'b1);
        reset = 1'b1;
        tick("reset_over_stall");
        chk("reset_over_stall_const", bus.F_PC, 32'h3000);
        reset = 1'b0;

        drive(3'd3, 1'b0, 32'h3000, 16'h0, 26'h0, 32'h3002, 1'b0);
        tick("exc_misalign");
        drive(3'd3, 1'b0, 32'h3000, 16'h0, 26'h0, 32'h7000, 1'b0);
        tick("exc_high");
        drive(3'd3, 1'b0, 32'h3000, 16'h0, 26'h0, 32'h2FFC, 1'b0);
        tick("exc_low");
        drive(3'd0, 1'b0, 32'h3000, 16'h0, 26'h0, 32'h0, 1'b0);
        tick("exc_clear");
        chk("exc_clear_pc", bus.F_PC, 32'h3000);
        chk("exc_clear_flag", {31'd0, bus.F_ExcAdEL}, 32'd0);

        drive(3'd3, 1'b0, 32'h3000, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
        tick("wrap_jr");
        drive(3'd0, 1'b0, 32'h3000, 16'h0, 26'h0, 32'h0, 1'b0);
        tick("wrap_seq");
        chk("wrap_const", bus.F_PC, 32'h0);

        for (int i = 0; i < 300; i++) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom), 32'h3000 + 4 * $urandom_range(0, 4095),
                  16'($urandom), 26'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                               : 32'h3000 + 4 * $urandom_range(0, 4200),
                  $urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 29) == 0);
            tick("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/f_pc_npc.md
Name: f_pc_npc

Overview:
- F-stage program counter register plus next-PC selection for the 5-stage MIPS pipeline.
- Consumes the D-stage branch decision (b_result from the compare unit), the D-stage jump/branch operands and the hazard-unit stall.
- Produces the fetch address F_PC and the link value for jal.
- Branch delay slot is architectural: the redirect is applied to the fetch after the delay-slot instruction.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- PC_LO, 32'h0000_3000, lowest legal instruction address; used only by the optional feature.
- PC_HI, 32'h0000_6FFC, highest legal instruction address; used only by the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit freezes F and D; PC holds.
- NPCOp  in  3  next-PC select from D-stage control: 000 seq, 001 branch, 010 j/jal, 011 jr; others treated as seq.
- b_result  in  1  compare-unit outcome for the D-stage branch.
- D_PC  in  32  PC of the instruction in D.
- D_imm16  in  16  branch offset field.
- D_instr_index  in  26  j/jal target field.
- D_rs_val  in  32  forwarded rs value for jr.
- F_PC  out  32  current fetch address (registered).
- D_link  out  32  D_PC+8, the jal/jalr link value (combinational).
- F_ExcAdEL  out  1  fetch address error; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset: on a rising clk edge with reset=1, F_PC<=RESET_PC and F_ExcAdEL<=0. Reset overrides stall.
- Normal update, no reset and stall=0: F_PC<=npc, with npc selected by NPCOp:
  - seq: F_PC+4.
  - branch: if b_result=1, D_PC+4+(sign_extend(D_imm16)<<2); if b_result=0, F_PC+4.
  - j/jal: {D_PC[31:28], D_instr_index, 2'b00}.
  - jr: D_rs_val.
  - undefined codes: F_PC+4.
- Delay slot: when D holds a branch or jump, F is already fetching D_PC+4 (the delay slot). The redirect takes effect at the next edge, so the delay slot always executes; no flush output exists.
- stall=1: F_PC holds its value, and NPCOp, b_result and D_rs_val are ignored that cycle. The same D instruction is re-evaluated after the stall, so a jr waiting on a forwarded rs resolves correctly.
- Arithmetic: all additions are 32-bit modulo 2^32, with no overflow detection. Wrap-around (F_PC=32'hFFFF_FFFC gives 32'h0000_0000) is legal in the datapath.
- Latency: the redirect is visible on F_PC one cycle after the branch is in D.
- D_link is purely combinational from D_PC.
- Back-to-back control transfers are handled with no extra state; each cycle's D instruction decides.
- The block assumes the hazard unit never stalls with an unresolved branch and also expects progress.

Optional Feature:
- Macro: NPC_ALIGN_EXC_EN.
- Enabled:
  - F_ExcAdEL is a register updated on the same edges as F_PC, and holds during stall. It is set when the new F_PC[1:0]!=0, or the new F_PC<PC_LO, or the new F_PC>PC_HI; otherwise it is cleared.
  - Reset clears it.
  - F_PC still loads the offending value; the downstream fetch logic substitutes a nop.
- Disabled: F_ExcAdEL is constant 0, and the PC_LO/PC_HI comparators are not built.

Decomposition:
- Shared package or header: NPCOp encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR), RESET_PC, PC_LO, PC_HI.
- Sub-module npc_calc: purely combinational next-PC computation from NPCOp, b_result, F_PC, D_PC, D_imm16, D_instr_index and D_rs_val.
- f_pc_npc keeps the register, stall/reset priority and the optional exception flag.

Test Plan:
- Reset then 3 cycles of seq → F_PC 0x3000, 0x3004, 0x3008, 0x300C; D_link follows D_PC+8.
- D_PC=0x3004, branch, imm16=0xFFFF, b_result=1 → next F_PC=0x3004; with b_result=0 → F_PC+4.
- j with D_PC=0x3010, index=26'h0000C10 → F_PC=0x0000_3040; jr with D_rs_val=0x3100 → F_PC=0x3100.
- jr with stall=1 for 2 cycles while D_rs_val changes 0x0→0x3200, then stall=0 → F_PC holds through the stall, then becomes 0x3200.
- Assert reset while stall=1 with a branch pending → F_PC=0x3000 on the next edge.
- With NPC_ALIGN_EXC_EN: jr to 0x3002 → F_ExcAdEL=1; jr to 0x7000 → F_ExcAdEL=1; a subsequent seq from 0x3000 → F_ExcAdEL=0. Without the macro, F_ExcAdEL stays 0 in all cases.
